// File: rtl/mixer_pkg.sv
// Shared types and default sizing for the signal mixer.
package mixer_pkg;

    // Default sizing; the mixer top re-exposes these as overridable parameters.
    localparam int unsigned DEF_NUM_VOICES = 4;
    localparam int unsigned DEF_SAMPLE_W   = 8;
    localparam int unsigned DEF_VOL_W      = 4;

    // Accumulator holds a full sum of all voices without overflow.
    localparam int unsigned ACC_W      = DEF_SAMPLE_W + $clog2(DEF_NUM_VOICES);
    localparam int unsigned PROD_W     = ACC_W + DEF_VOL_W;
    localparam int unsigned SAMPLE_MAX = (1 << DEF_SAMPLE_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2
    } mix_state_t;

endpackage

// File: rtl/mix_scaler.sv
// Combinational master-volume scaler: (acc * volume) >> VOL_W, saturated to SAMPLE_W bits.
module mix_scaler #(
    parameter int unsigned ACC_W    = mixer_pkg::ACC_W,
    parameter int unsigned SAMPLE_W = mixer_pkg::DEF_SAMPLE_W,
    parameter int unsigned VOL_W    = mixer_pkg::DEF_VOL_W
) (
    input  logic [ACC_W-1:0]    acc,
    input  logic [VOL_W-1:0]    volume,
    output logic [SAMPLE_W-1:0] result
);

    localparam int unsigned PROD_W = ACC_W + VOL_W;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  mixed;
    logic              overflow;
    // Fractional bits dropped by the gain shift.
    logic              unused_frac;

    // Multiply, drop the fractional gain bits, clamp anything above full scale.
    always_comb begin
        prod        = {{VOL_W{1'b0}}, acc} * {{ACC_W{1'b0}}, volume};
        mixed       = prod[PROD_W-1:VOL_W];
        unused_frac = ^prod[VOL_W-1:0];
        overflow    = |mixed[ACC_W-1:SAMPLE_W];
        result      = overflow ? {SAMPLE_W{1'b1}} : mixed[SAMPLE_W-1:0];
    end

endmodule

// File: rtl/signal_mixer.sv
// Time-multiplexed voice mixer feeding the PWM stage: snapshot on tick, sum one voice per
// cycle, apply master volume with saturation, then present a held duty-cycle sample.
module signal_mixer
    import mixer_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
    parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
    parameter int unsigned VOL_W      = DEF_VOL_W
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [VOL_W-1:0]               volume,
    input  logic                           clr_overrun,
    output logic [SAMPLE_W-1:0]            final_out,
    output logic                           out_valid,
    output logic                           mix_active,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned IDX_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned ACC_BITS = SAMPLE_W + IDX_BITS;

    mix_state_t state_q, state_d;

    logic [NUM_VOICES*SAMPLE_W-1:0] voice_snap_q, voice_snap_d;
    logic [NUM_VOICES-1:0]          en_snap_q, en_snap_d;
    logic [VOL_W-1:0]               vol_snap_q, vol_snap_d;
    logic [ACC_BITS-1:0]            acc_q, acc_d;
    logic [IDX_BITS-1:0]            idx_q, idx_d;
    logic [SAMPLE_W-1:0]            final_out_q, final_out_d;
    logic                           out_valid_q, out_valid_d;
    logic                           mix_active_q, mix_active_d;
    logic                           overrun_q, overrun_d;

    logic [SAMPLE_W-1:0]            cur_sample;
    logic [SAMPLE_W-1:0]            addend;
    logic [SAMPLE_W-1:0]            scaled;

    mix_scaler #(
        .ACC_W   (ACC_BITS),
        .SAMPLE_W(SAMPLE_W),
        .VOL_W   (VOL_W)
    ) u_scaler (
        .acc   (acc_q),
        .volume(vol_snap_q),
        .result(scaled)
    );

    // Select the snapshot voice addressed by the accumulation index, masked by its enable.
    always_comb begin
        cur_sample = voice_snap_q[idx_q*SAMPLE_W +: SAMPLE_W];
        addend     = en_snap_q[idx_q] ? cur_sample : '0;
    end

    // Next-state logic for the mix FSM and all datapath registers.
    always_comb begin
        state_d      = state_q;
        voice_snap_d = voice_snap_q;
        en_snap_d    = en_snap_q;
        vol_snap_d   = vol_snap_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        final_out_d  = final_out_q;
        out_valid_d  = 1'b0;
        mix_active_d = mix_active_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    voice_snap_d = voice_in;
                    en_snap_d    = voice_en;
                    vol_snap_d   = volume;
                    acc_d        = '0;
                    idx_d        = '0;
                    mix_active_d = |voice_en;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + {{IDX_BITS{1'b0}}, addend};
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_BITS'(NUM_VOICES - 1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                final_out_d = scaled;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tick that cannot be accepted is dropped but flagged; setting beats clearing.
        if (sample_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q      <= IDLE;
            voice_snap_q <= '0;
            en_snap_q    <= '0;
            vol_snap_q   <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            final_out_q  <= '0;
            out_valid_q  <= 1'b0;
            mix_active_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            voice_snap_q <= voice_snap_d;
            en_snap_q    <= en_snap_d;
            vol_snap_q   <= vol_snap_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            final_out_q  <= final_out_d;
            out_valid_q  <= out_valid_d;
            mix_active_q <= mix_active_d;
            overrun_q    <= overrun_d;
        end
    end

    // Outputs come straight from registers; busy decodes the registered state.
    always_comb begin
        final_out  = final_out_q;
        out_valid  = out_valid_q;
        mix_active = mix_active_q;
        overrun    = overrun_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_signal_mixer.sv
// Directed self-checking bench for signal_mixer at default parameters.
module tb_signal_mixer;

    logic        clk;
    logic        n_rst;
    logic        sample_tick;
    logic [31:0] voice_in;
    logic [3:0]  voice_en;
    logic [3:0]  volume;
    logic        clr_overrun;
    logic [7:0]  final_out;
    logic        out_valid;
    logic        mix_active;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    signal_mixer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sample_tick(sample_tick),
        .voice_in   (voice_in),
        .voice_en   (voice_en),
        .volume     (volume),
        .clr_overrun(clr_overrun),
        .final_out  (final_out),
        .out_valid  (out_valid),
        .mix_active (mix_active),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One mix: tick at cycle 0, observe cycles 1..8 at the falling edge.
    task automatic do_mix(input logic [31:0] v, input logic [3:0] e, input logic [3:0] vol,
                          output int vcount, output int vcycle, output logic [7:0] vout,
                          output logic [7:0] bmask, output logic act1);
        vcount = 0;
        vcycle = -1;
        vout   = '0;
        bmask  = '0;
        act1   = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                bmask[c-1] = busy;
                if (c == 1) act1 = mix_active;
                if (out_valid) begin
                    vcount++;
                    vcycle = c;
                    vout   = final_out;
                end
            end
            sample_tick = (c == 0);
            if (c == 0) begin
                voice_in = v;
                voice_en = e;
                volume   = vol;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (final_out !== 8'd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", final_out); end
        n_checks++; if (mix_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", mix_active); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_rst = 1'b0;
    endtask

    // Checks one mix against hand-computed expectations (result at cycle 6, busy cycles 1..5).
    task automatic test_mix(input string name, input logic [31:0] v, input logic [3:0] e,
                            input logic [3:0] vol, input logic [7:0] exp_out, input logic exp_act);
        int cnt, cyc;
        logic [7:0] o, m;
        logic a;
        do_mix(v, e, vol, cnt, cyc, o, m, a);
        n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL %s_count got %0d want 1", name, cnt); end
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL %s_cycle got %0d want 6", name, cyc); end
        n_checks++; if (o !== exp_out) begin n_fail++; $display("FAIL %s_out got %0d want %0d", name, o, exp_out); end
        n_checks++; if (m !== 8'b0001_1111) begin n_fail++; $display("FAIL %s_busy got %b want 00011111", name, m); end
        n_checks++; if (a !== exp_act) begin n_fail++; $display("FAIL %s_active got %b want %b", name, a, exp_act); end
    endtask

    task automatic test_overrun();
        int cnt = 0, cyc = -1;
        logic [7:0] o = '0;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (out_valid) begin cnt++; cyc = c; o = final_out; end
            if (c == 4) begin
                n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", overrun); end
            end
            sample_tick = (c == 0) || (c == 3);
            if (c == 0) begin
                voice_in = {8'd40, 8'd30, 8'd20, 8'd10};
                voice_en = 4'b1111;
                volume   = 4'd8;
            end
            if (c == 2) begin
                voice_in = {4{8'd255}};
                voice_en = 4'b0000;
                volume   = 4'd15;
            end
        end
        n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL ovr_count got %0d want 1", cnt); end
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL ovr_cycle got %0d want 6", cyc); end
        n_checks++; if (o !== 8'd50) begin n_fail++; $display("FAIL ovr_out got %0d want 50", o); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
    endtask

    // Tick+clear during SCALE (set wins), then a tick right after SCALE is accepted.
    task automatic test_back_to_back();
        int cnt = 0;
        logic [7:0] o6 = '0, o12 = '0;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (c == 6) o6 = final_out;
                if (c == 12) o12 = final_out;
            end
            if (c == 6) begin
                n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_setwins got %b want 1", overrun); end
            end
            if (c == 7) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", busy); end
            end
            sample_tick = (c == 0) || (c == 5) || (c == 6);
            clr_overrun = (c == 5);
            if (c == 0) begin
                voice_in = {8'd40, 8'd30, 8'd20, 8'd10};
                voice_en = 4'b1111;
                volume   = 4'd8;
            end
            if (c == 6) begin
                voice_in = {4{8'd255}};
                volume   = 4'd4;
            end
        end
        n_checks++; if (cnt !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", cnt); end
        n_checks++; if (o6 !== 8'd50) begin n_fail++; $display("FAIL b2b_first got %0d want 50", o6); end
        n_checks++; if (o12 !== 8'd255) begin n_fail++; $display("FAIL b2b_second got %0d want 255", o12); end
    endtask

    task automatic test_mid_reset();
        int cnt = 0;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            sample_tick = (c == 0) || (c == 2);
            if (c == 0) begin
                voice_in = {4{8'd255}};
                voice_en = 4'b1111;
                volume   = 4'd4;
            end
        end
        // Now in cycle 3; a tick was ignored at cycle 2.
        sample_tick = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_ovr got %b want 1", overrun); end
        n_rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got %b want 0", busy); end
        n_checks++; if (final_out !== 8'd0) begin n_fail++; $display("FAIL mrst_out got %0d want 0", final_out); end
        n_checks++; if (mix_active !== 1'b0) begin n_fail++; $display("FAIL mrst_active got %b want 0", mix_active); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mrst_ovr got %b want 0", overrun); end
        @(negedge clk);
        n_rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL mrst_novalid got %0d want 0", cnt); end
        // 10+20+30+40=100, *15=1500, >>4 = 93
        test_mix("post_rst", {8'd40, 8'd30, 8'd20, 8'd10}, 4'b1111, 4'd15, 8'd93, 1'b1);
    endtask

    initial begin
        n_rst       = 1'b1;
        sample_tick = 1'b0;
        voice_in    = '0;
        voice_en    = '0;
        volume      = '0;
        clr_overrun = 1'b0;
        test_reset();
        // 1020*4 = 4080 >> 4 = 255
        test_mix("full_v4", {4{8'd255}}, 4'b1111, 4'd4, 8'd255, 1'b1);
        // 150*8 = 1200 >> 4 = 75
        test_mix("partial", {8'd0, 8'd0, 8'd50, 8'd100}, 4'b0011, 4'd8, 8'd75, 1'b1);
        // 1020*15 = 15300 >> 4 = 956 -> saturates to 255
        test_mix("saturate", {4{8'd255}}, 4'b1111, 4'd15, 8'd255, 1'b1);
        test_mix("all_off", {4{8'd200}}, 4'b0000, 4'd15, 8'd0, 1'b0);
        test_mix("vol_zero", {4{8'd255}}, 4'b1111, 4'd0, 8'd0, 1'b1);
        // Only voice 2 enabled: 30*15 = 450 >> 4 = 28
        test_mix("one_voice", {8'd40, 8'd30, 8'd20, 8'd10}, 4'b0100, 4'd15, 8'd28, 1'b1);
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
